// File: rtl/uart_rx_parity_if.sv
// uart_rx_parity_if
//   Bundles the serial-side inputs and parallel-side outputs of the UART
//   receiver.
//
//   Signals:
//     rx          serial line, idle high, asynchronous to clk
//     s_tick      1-clk strobe at 16x the baud rate
//     rx_dout     received data word, held until the next rx_done
//     rx_done     1-clk pulse when a frame completes
//     parity_err  even-parity check failed on the last frame
//     frame_err   stop bit of the last frame was sampled low
//     rx_busy     receiver is inside a frame
//
//   Modports:
//     master  the receiver. It consumes rx/s_tick and drives the results.
//     slave   the line driver, baud generator and host side.
interface uart_rx_parity_if #(
    parameter int D_BITS = 8
);
    logic              rx;
    logic              s_tick;
    logic [D_BITS-1:0] rx_dout;
    logic              rx_done;
    logic              parity_err;
    logic              frame_err;
    logic              rx_busy;

    modport master (
        input  rx,
        input  s_tick,
        output rx_dout,
        output rx_done,
        output parity_err,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        output s_tick,
        input  rx_dout,
        input  rx_done,
        input  parity_err,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_parity.sv
// uart_rx_parity
//   UART receiver with even-parity checking. It is the counterpart of the
//   parity-generating transmitter.
//
//   Frame format:
//     start bit (0), then D_BITS data bits LSB first, then one even-parity bit,
//     then the stop bit (1).
//
//   Sampling:
//     The line is oversampled with s_tick at 16 ticks per bit. Each bit is
//     sampled at its centre, counted in 16-tick steps from the centre of the
//     start bit.
//
//   Ports:
//     clk    system clock. All logic runs on the rising edge.
//     reset  asynchronous, active-high reset.
//     bus    uart_rx_parity_if.master: rx, s_tick in; rx_dout, rx_done,
//            parity_err, frame_err, rx_busy out.
//
//   Parameters:
//     D_BITS   data bits per frame (1..8)
//     SB_TICK  s_tick count spent in the stop bit (16 = one stop bit)
module uart_rx_parity #(
    parameter int D_BITS  = 8,
    parameter int SB_TICK = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_rx_parity_if.master       bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [2:0] N_LAST = 3'(D_BITS - 1);
    localparam logic [3:0] S_LAST = 4'(SB_TICK - 1);

    state_t            state_q, state_d;
    logic [3:0]        s_q, s_d;
    logic [2:0]        n_q, n_d;
    logic [D_BITS-1:0] b_q, b_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [D_BITS-1:0] dout_q, dout_d;
    logic              done_q, done_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              rx_s;

    assign rx_s = sync2_q;

    // Next-state logic.
    // rx goes through two synchronizer flops, and every decision below uses
    // the synchronized copy rx_s. The tick counter s and the bit index n only
    // move on s_tick. The only exception is the IDLE->START entry: it reacts
    // on the first clock that rx_s goes low, so back-to-back frames lose no
    // time.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        par_d        = par_q;
        perr_d       = perr_q;
        sync1_d      = bus.rx;
        sync2_d      = sync1_q;
        dout_d       = dout_q;
        done_d       = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = 4'd0;
                    par_d   = 1'b0;
                end
            end

            START: begin
                if (bus.s_tick) begin
                    if (s_q == 4'd7) begin
                        // At the centre of the start bit, a line that is
                        // already high again was only a glitch.
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = 4'd0;
                            n_d     = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end

            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == 4'd15) begin
                        s_d              = 4'd0;
                        // Data arrives LSB first. Shifting in at the MSB
                        // leaves the first bit at b[0] once all bits are in.
                        b_d              = b_q >> 1;
                        b_d[D_BITS-1]    = rx_s;
                        par_d            = par_q ^ rx_s;
                        if (n_q == N_LAST) begin
                            state_d = PARITY;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end

            PARITY: begin
                if (bus.s_tick) begin
                    if (s_q == 4'd15) begin
                        s_d     = 4'd0;
                        perr_d  = par_q ^ rx_s;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end

            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d          = 4'd0;
                        done_d       = 1'b1;
                        dout_d       = b_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ~rx_s;
                        state_d      = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    // The synchronizer resets to the idle-high line level. This stops a
    // reset release from looking like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            s_q          <= 4'd0;
            n_q          <= 3'd0;
            b_q          <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            dout_q       <= '0;
            done_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            par_q        <= par_d;
            perr_q       <= perr_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            dout_q       <= dout_d;
            done_q       <= done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.rx_dout    = dout_q;
    assign bus.rx_done    = done_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.rx_busy    = (state_q != IDLE);

endmodule
